sram_arbiter: RTL



---
 rtl/sram_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Two-client arbiter for the single off-chip SRAM port: pixel-fetch reads vs. result writebacks.
// Optional per-client completion counters are enabled with `define SRAM_ARB_PERF_EN.
module sram_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 24,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  output logic              busy,
`ifdef SRAM_ARB_PERF_EN
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
`endif
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] r_data,
  output logic              read_enable,
  output logic              write_enable
);

  typedef enum logic [1:0] {IDLE, TURN, RD_ACC, WR_ACC} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last_grant_wr;
  logic       last_op_wr;
  logic       op_wr;

  logic rd_valid, wr_valid, grant_rd, grant_wr;

  // A client whose done is high this cycle is finishing, not asking again.
  assign rd_valid = rd_req && !rd_done;
  assign wr_valid = wr_req && !wr_done;
  assign grant_rd = rd_valid && (!wr_valid || last_grant_wr);
  assign grant_wr = wr_valid && !grant_rd;

  // NOTE: all state and outputs update with non-blocking assignments so every
  // read in this block sees the pre-edge value, regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant_wr <= 1'b1;
      last_op_wr    <= 1'b0;
      op_wr         <= 1'b0;
      rd_data       <= '0;
      rd_done       <= 1'b0;
      wr_done       <= 1'b0;
      busy          <= 1'b0;
      address       <= '0;
      w_data        <= '0;
      read_enable   <= 1'b0;
      write_enable  <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_rd || grant_wr) begin
            op_wr         <= grant_wr;
            last_grant_wr <= grant_wr;
            address       <= grant_wr ? wr_addr : rd_addr;
            if (grant_wr) w_data <= wr_data;
            cnt  <= CNT_LOAD;
            busy <= 1'b1;
            // A direction change costs one dead cycle on the bus.
            if (grant_wr != last_op_wr) begin
              state <= TURN;
            end else if (grant_wr) begin
              state        <= WR_ACC;
              write_enable <= 1'b1;
            end else begin
              state       <= RD_ACC;
              read_enable <= 1'b1;
            end
          end
        end
        TURN: begin
          cnt <= CNT_LOAD;
          if (op_wr) begin
            state        <= WR_ACC;
            write_enable <= 1'b1;
          end else begin
            state       <= RD_ACC;
            read_enable <= 1'b1;
          end
        end
        RD_ACC: begin
          if (cnt == 4'd0) begin
            rd_data     <= r_data;
            rd_done     <= 1'b1;
            read_enable <= 1'b0;
            last_op_wr  <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_ACC: begin
          if (cnt == 4'd0) begin
            wr_done      <= 1'b1;
            write_enable <= 1'b0;
            last_op_wr   <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_ARB_PERF_EN
  // Saturating completion counters, bumped on the cycle each done pulse is seen.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_done && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (wr_done && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule
